// File: rtl/inst_fetch_pkg.sv
// Shared types for the NECPU instruction fetch stage.
// Build option: IFETCH_ZERO_HALT_EN (see inst_fetch.sv).
package inst_fetch_pkg;
  localparam int          DEFAULT_ADDR_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  typedef logic [31:0]               inst_t;
  typedef logic [DEFAULT_ADDR_W-1:0] pc_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue.sv
// In-order fetch queue: DEPTH-entry synchronous FIFO of fetch_entry_t with flush.
// Flush wins over push and pop in the same cycle.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       din,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// NECPU instruction fetch: PC register, ROM address, in-order queue to decode.
// Build option: IFETCH_ZERO_HALT_EN stops fetching after a fetched all-zero word.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Decode handshake: an entry transfers when inst_valid and inst_ready are
  // both high at a rising edge; a redirect in that cycle discards the transfer.
  logic              pc_en;
  logic [ADDR_W-1:0] pc;
  logic              pop;
  logic              push;
  logic              halted;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  unused_q_count;
  fetch_entry_t      q_din;
  fetch_entry_t      q_head;

  assign pop        = inst_valid & inst_ready;
  assign pc_en      = ~redirect_valid & ~halted;
  assign push       = pc_en & (~q_full | pop);
  assign imem_addr  = pc;
  assign inst_valid = ~q_empty;
  assign inst_out   = q_head.inst;
  assign inst_pc    = ADDR_W'(q_head.pc);
  assign q_din      = '{pc: pc_t'(pc), inst: imem_inst};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + 1'b1;
  end

`ifdef IFETCH_ZERO_HALT_EN
  // The ROM returns zero past its end, so a zero word marks the end of program.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             halted <= 1'b0;
    else if (redirect_valid)             halted <= 1'b0;
    else if (push && imem_inst == 32'd0) halted <= 1'b1;
  end
  assign fetch_halted = halted;
`else
  assign halted       = 1'b0;
  assign fetch_halted = 1'b0;
`endif

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .head  (q_head),
    .count (unused_q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch; honours IFETCH_ZERO_HALT_EN.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_halted;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef IFETCH_ZERO_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  // ROM model: words 0..25 hold 0x1000_0000+i, everything else reads zero
  assign imem_inst = (imem_addr <= 32'd25) ? 32'h1000_0000 + imem_addr : 32'd0;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_halted   (fetch_halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                     input logic [31:0] eaddr, input logic eh);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_inst = einst; v.e_addr = eaddr; v.e_halt = eh;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    int lat;

    // rows: inputs for this cycle, outputs expected before this cycle's edge
    add(1, 0, 0,            0, 0,            0,            0,            0);
    add(1, 0, 0,            1, 0,            32'h10000000, 1,            0);
    add(1, 0, 0,            1, 1,            32'h10000001, 2,            0);
    add(0, 0, 0,            1, 2,            32'h10000002, 3,            0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0,          1, 2,            32'h10000002, 4,            0);
    add(1, 1, 7,            1, 2,            32'h10000002, 4,            0);
    add(1, 0, 0,            0, 0,            0,            7,            0);
    add(1, 0, 0,            1, 7,            32'h10000007, 8,            0);
    add(1, 1, 32'hFFFFFFFF, 1, 8,            32'h10000008, 9,            0);
    add(1, 0, 0,            0, 0,            0,            32'hFFFFFFFF, 0);
    add(1, 0, 0,            1, 32'hFFFFFFFF, 0,            0,            HALT_EN);
`ifdef IFETCH_ZERO_HALT_EN
    add(1, 1, 24,           0, 0,            0,            0,            1);
`else
    add(1, 1, 24,           1, 0,            32'h10000000, 1,            0);
`endif
    add(1, 0, 0,            0, 0,            0,            24,           0);
    add(1, 0, 0,            1, 24,           32'h10000018, 25,           0);
    add(1, 0, 0,            1, 25,           32'h10000019, 26,           0);
    add(1, 0, 0,            1, 26,           0,            27,           HALT_EN);
`ifdef IFETCH_ZERO_HALT_EN
    add(1, 0, 0,            0, 0,            0,            27,           1);
    add(1, 1, 0,            0, 0,            0,            27,           1);
`else
    add(1, 0, 0,            1, 27,           0,            28,           0);
    add(1, 1, 0,            1, 28,           0,            29,           0);
`endif
    add(1, 0, 0,            0, 0,            0,            0,            0);
    add(0, 0, 0,            1, 0,            32'h10000000, 1,            0);

    rst = 1'b1;
    drive(0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", {31'd0, inst_valid}, 0);
    check("reset_addr", imem_addr, 0);
    check("reset_inst_out", inst_out, 0);
    check("reset_inst_pc", inst_pc, 0);
    check("reset_halted", {31'd0, fetch_halted}, 0);

    foreach (vecs[i]) begin
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_halted", i), {31'd0, fetch_halted}, {31'd0, vecs[i].e_halt});
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_pc", i), inst_pc, vecs[i].e_pc);
        check($sformatf("v%0d_inst", i), inst_out, vecs[i].e_inst);
      end
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
    end

    // queue now full (pcs 0,1) with ready low: pc must stall at 2
    @(negedge clk);
    check("full_valid", {31'd0, inst_valid}, 1);
    check("full_head_pc", inst_pc, 0);
    check("full_stall_addr", imem_addr, 2);

    // asynchronous reset mid-stream, observed before any clock edge
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, inst_valid}, 0);
    check("async_rst_addr", imem_addr, 0);
    check("async_rst_halted", {31'd0, fetch_halted}, 0);

    // first fetch after deassertion: valid one edge later, bounded wait
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0);
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (inst_valid) begin
        lat = c;
        break;
      end
    end
    check("restart_latency", lat, 1);
    check("restart_pc", inst_pc, 0);
    check("restart_inst", inst_out, 32'h10000000);
    @(posedge clk);
    #1;
    check("restart_next_pc", inst_pc, 1);
    check("restart_next_inst", inst_out, 32'h10000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
